// File: rtl/display_pkg.sv
// display_pkg: shared constants for the six-digit seven-segment scanner.
package display_pkg;
  localparam int NUM_DIGITS = 6;
  localparam logic DP_OFF = 1'b1;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/digital_display_if.sv
// digital_display_if: digit nibbles in, active-low anode/segment drive out.
interface digital_display_if;
  logic [3:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [5:0] an;
  logic [7:0] sseg;
  modport master (output hex0, hex1, hex2, hex3, hex4, hex5, input an, sseg);
  modport slave (input hex0, hex1, hex2, hex3, hex4, hex5, output an, sseg);
endinterface

// File: rtl/hex_to_sseg.sv
// hex_to_sseg: combinational nibble to active-low {g,f,e,d,c,b,a} decoder.
module hex_to_sseg
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/digital_display.sv
// digital_display: scans six common-anode digits, one per SCAN_DIV-cycle slot.
module digital_display
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int CNT_W = 20
) (
  input logic clk,
  input logic rst,
  digital_display_if.slave dif
);
  logic [CNT_W-1:0] div_q, div_d;
  logic [2:0] sel_q, sel_d;
  logic [5:0] an_q, an_d;
  logic [7:0] sseg_q, sseg_d;
  logic [3:0] nib;
  logic [6:0] seg;
  logic wrap;
  hex_to_sseg u_dec (.hex(nib), .seg(seg));
  always_comb begin
    wrap = div_q == CNT_W'(SCAN_DIV - 1);
    div_d = wrap ? '0 : div_q + 1'b1;
    // out-of-range select recovers to digit 0 on the next edge
    sel_d = (sel_q >= 3'(NUM_DIGITS)) ? '0 :
            wrap ? ((sel_q == 3'(NUM_DIGITS - 1)) ? '0 : sel_q + 3'd1) : sel_q;
    case (sel_q)
      3'd1: nib = dif.hex1;
      3'd2: nib = dif.hex2;
      3'd3: nib = dif.hex3;
      3'd4: nib = dif.hex4;
      3'd5: nib = dif.hex5;
      default: nib = dif.hex0;
    endcase
    an_d = ~(6'b1 << sel_q);
    sseg_d = {DP_OFF, seg};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      sel_q <= '0;
      an_q <= '1;
      sseg_q <= '1;
    end else begin
      div_q <= div_d;
      sel_q <= sel_d;
      an_q <= an_d;
      sseg_q <= sseg_d;
    end
  end
  assign dif.an = an_q;
  assign dif.sseg = sseg_q;
endmodule

// File: tb/tb_digital_display.sv
// tb_digital_display: directed checks of scan order, decode, latency and reset.
module tb_digital_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] tbl [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  digital_display_if dif();
  digital_display #(.SCAN_DIV(16), .CNT_W(20)) dut (.clk(clk), .rst(rst), .dif(dif));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    checks++;
    if (dif.an !== 6'h3F && $countones(~dif.an) != 1) begin
      errors++;
      $display("FAIL invariant an=%b", dif.an);
    end
  end
  task automatic set_hex(input logic [3:0] a, b, c, d, e, f);
    dif.hex0 = a; dif.hex1 = b; dif.hex2 = c;
    dif.hex3 = d; dif.hex4 = e; dif.hex5 = f;
  endtask
  task automatic restart();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      set_hex(4'(i), 4'(i + 3), 4'(i + 5), 4'(i + 7), 4'(i + 9), 4'(i + 11));
      @(negedge clk);
      checks++;
      if (dif.an !== 6'h3F || dif.sseg !== 8'hFF) begin
        errors++;
        $display("FAIL reset cyc=%0d an=%b sseg=%h want 111111/ff", i, dif.an, dif.sseg);
      end
    end
  endtask
  task automatic test_scan_order();
    set_hex(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    restart();
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 6; d++)
        for (int c = 0; c < 16; c++) begin
          @(posedge clk); #1;
          checks++;
          if (dif.an !== ~(6'b1 << d) || dif.sseg !== tbl[d + 1]) begin
            errors++;
            $display("FAIL scan f=%0d d=%0d c=%0d an=%b sseg=%h want %b/%h",
                     f, d, c, dif.an, dif.sseg, ~(6'b1 << d), tbl[d + 1]);
          end
        end
  endtask
  task automatic test_decode();
    set_hex(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    restart();
    for (int v = 0; v < 16; v++) begin
      dif.hex0 = 4'(v);
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        checks++;
        if (dif.an !== 6'b111110 || dif.sseg !== tbl[v]) begin
          errors++;
          $display("FAIL decode v=%h c=%0d an=%b sseg=%h want 111110/%h", v, c, dif.an, dif.sseg, tbl[v]);
        end
      end
      repeat (80) @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic test_mid_slot();
    set_hex(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    restart();
    repeat (35) @(posedge clk);
    #1;
    checks++;
    if (dif.an !== 6'b111011 || dif.sseg !== 8'hB0) begin
      errors++;
      $display("FAIL midslot_before an=%b sseg=%h want 111011/b0", dif.an, dif.sseg);
    end
    @(negedge clk) dif.hex2 = 4'd8;
    #1;
    checks++;
    if (dif.sseg !== 8'hB0) begin
      errors++;
      $display("FAIL midslot_hold sseg=%h want b0", dif.sseg);
    end
    @(posedge clk); #1;
    checks++;
    if (dif.an !== 6'b111011 || dif.sseg !== 8'h80) begin
      errors++;
      $display("FAIL midslot_after an=%b sseg=%h want 111011/80", dif.an, dif.sseg);
    end
  endtask
  task automatic test_reset_mid();
    set_hex(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    restart();
    repeat (70) @(posedge clk);
    #1;
    checks++;
    if (dif.an !== 6'b101111 || dif.sseg !== 8'h92) begin
      errors++;
      $display("FAIL rstmid_pre an=%b sseg=%h want 101111/92", dif.an, dif.sseg);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dif.an !== 6'h3F || dif.sseg !== 8'hFF) begin
      errors++;
      $display("FAIL rstmid_async an=%b sseg=%h want 111111/ff", dif.an, dif.sseg);
    end
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
      checks++;
      if ((c < 16 && (dif.an !== 6'b111110 || dif.sseg !== 8'hF9)) ||
          (c == 16 && (dif.an !== 6'b111101 || dif.sseg !== 8'hA4))) begin
        errors++;
        $display("FAIL rstmid_restart c=%0d an=%b sseg=%h", c, dif.an, dif.sseg);
      end
    end
  endtask
  initial begin
    test_reset();
    test_scan_order();
    test_decode();
    test_mid_slot();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
